// File: rtl/mdu.sv
// mdu: multicycle multiply/divide unit owning the HI/LO register pair
//   clk      : clock, all state updates on the rising edge
//   reset_n  : asynchronous active-low reset
//   Start    : one-cycle launch request for mult/multu/div/divu (and madd family)
//   MDUOp    : operation select (1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//              7 madd, 8 maddu, 9 msub, 10 msubu when MDU_MADD_EN is defined)
//   Data1    : rs operand (dividend / multiplicand / mthi-mtlo source)
//   Data2    : rt operand (divisor / multiplier)
//   Flush    : EX-stage kill, suppresses any launch or HI/LO write this cycle
//   Busy     : registered, high for exactly MULT_CYCLES/DIV_CYCLES after launch
//   HI, LO   : result registers
// Optional feature macro: MDU_MADD_EN (multiply-accumulate opcodes 7..10).
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MTHI = 4'd5, OP_MTLO = 4'd6;
  typedef enum logic {IDLE, RUN} state_t;
  // how the pending result is applied to {HI,LO} at completion
  typedef enum logic [1:0] {P_WR, P_ADD, P_SUB, P_NONE} pend_t;
  state_t state;
  pend_t pend_k, kind;
  logic [CW-1:0] cnt;
  logic [63:0] pend, res, prod, a_ext, b_ext;
  logic [31:0] n_mag, d_mag, d_safe, q, r, quo, rem;
  logic is_mul, is_div, is_mac, mac_sub, mac_sgn, sgn, idle_ok, launch;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD = 4'd7, OP_MADDU = 4'd8, OP_MSUB = 4'd9, OP_MSUBU = 4'd10;
  assign is_mac  = MDUOp == OP_MADD || MDUOp == OP_MADDU || MDUOp == OP_MSUB || MDUOp == OP_MSUBU;
  assign mac_sub = MDUOp == OP_MSUB || MDUOp == OP_MSUBU;
  assign mac_sgn = MDUOp == OP_MADD || MDUOp == OP_MSUB;
`else
  assign is_mac  = 1'b0;
  assign mac_sub = 1'b0;
  assign mac_sgn = 1'b0;
`endif
  assign is_mul  = MDUOp == OP_MULT || MDUOp == OP_MULTU;
  assign is_div  = MDUOp == OP_DIV || MDUOp == OP_DIVU;
  assign sgn     = MDUOp == OP_MULT || MDUOp == OP_DIV || mac_sgn;
  assign idle_ok = state == IDLE && !Flush;
  assign launch  = idle_ok && Start && (is_mul || is_div || is_mac);
  // low 64 bits of a 64x64 product of the extended operands equal the 32x32 result
  assign a_ext = {{32{sgn & Data1[31]}}, Data1};
  assign b_ext = {{32{sgn & Data2[31]}}, Data2};
  assign prod  = a_ext * b_ext;
  // signed division runs on magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude,
  // which makes the 0x80000000 / -1 overflow case fall out as LO=0x80000000, HI=0
  assign n_mag  = sgn && Data1[31] ? -Data1 : Data1;
  assign d_mag  = sgn && Data2[31] ? -Data2 : Data2;
  assign d_safe = Data2 == 32'd0 ? 32'd1 : d_mag;
  assign q      = n_mag / d_safe;
  assign r      = n_mag % d_safe;
  assign quo    = sgn && (Data1[31] ^ Data2[31]) ? -q : q;
  assign rem    = sgn && Data1[31] ? -r : r;
  assign res    = is_div ? {rem, quo} : prod;
  assign kind   = is_div ? (Data2 == 32'd0 ? P_NONE : P_WR) : is_mac ? (mac_sub ? P_SUB : P_ADD) : P_WR;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      cnt    <= '0;
      pend   <= '0;
      pend_k <= P_NONE;
      HI     <= '0;
      LO     <= '0;
    end else if (state == IDLE) begin
      if (launch) begin
        state  <= RUN;
        Busy   <= 1'b1;
        cnt    <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        pend   <= res;
        pend_k <= kind;
      end else if (idle_ok && MDUOp == OP_MTHI) HI <= Data1;
      else if (idle_ok && MDUOp == OP_MTLO) LO <= Data1;
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= IDLE;
        Busy  <= 1'b0;
        case (pend_k)
          P_WR:    {HI, LO} <= pend;
          P_ADD:   {HI, LO} <= {HI, LO} + pend;
          P_SUB:   {HI, LO} <= {HI, LO} - pend;
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed scoreboard bench for the mdu multiply/divide unit
module tb_mdu;
  logic clk = 0, reset_n = 0, Start = 0, Flush = 0, Busy;
  logic [3:0] MDUOp = 0;
  logic [31:0] Data1 = 0, Data2 = 0, HI, LO;
  logic [63:0] sb[$];
  logic [63:0] hl;
  int n_assert = 0, n_fail = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MDUOp(MDUOp), .Data1(Data1),
    .Data2(Data2), .Flush(Flush), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    Start = 1; MDUOp = op; Data1 = a; Data2 = b; Flush = fl;
    @(negedge clk);
    Start = 0; MDUOp = 0; Flush = 0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] d, input logic fl);
    MDUOp = op; Data1 = d; Flush = fl;
    @(negedge clk);
    MDUOp = 0; Flush = 0;
  endtask

  // counts remaining Busy cycles, then compares HI/LO against the scoreboard head
  task automatic wait_done(input string tag, input int n);
    int c = 0;
    while (Busy === 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_cycles"}, 64'(c), 64'(n));
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 64'(1), 64'(0));
    else begin
      hl = sb.pop_front();
      chk({tag, "_hi"}, 64'(HI), 64'(hl[63:32]));
      chk({tag, "_lo"}, 64'(LO), 64'(hl[31:0]));
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    int sa, sbv;
    sa = int'(a); sbv = int'(b);
    case (op)
      4'd1: begin sp = longint'(sa) * longint'(sbv); return 64'(sp); end
      4'd2: return 64'(a) * 64'(b);
      4'd3: return {32'(sa % sbv), 32'(sa / sbv)};
      default: return {a % b, a / b};
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [3:0] rop;
    #2;
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_hi", 64'(HI), 64'(0));
    chk("rst_lo", 64'(LO), 64'(0));
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    issue(4'd1, 32'hFFFFFFFD, 32'd5, 0);
    wait_done("mult_neg3x5", 5);
    sb.push_back({32'd1, 32'd3});
    issue(4'd4, 32'd7, 32'd2, 0);
    wait_done("divu_7_2", 10);
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 0);
    wait_done("div_neg7_2", 10);
    sb.push_back({32'd0, 32'd6});
    issue(4'd1, 32'd2, 32'd3, 0);
    @(negedge clk);
    issue(4'd3, 32'd9, 32'd3, 0);
    wait_done("mult_ignore_div", 3);
    mt(4'd6, 32'h12345678, 0);
    chk("mtlo_busy", 64'(Busy), 64'(0));
    chk("mtlo_lo", 64'(LO), 64'(32'h12345678));
    chk("mtlo_hi", 64'(HI), 64'(0));
    mt(4'd5, 32'hCAFEBABE, 0);
    chk("mthi_hi", 64'(HI), 64'(32'hCAFEBABE));
    chk("mthi_lo", 64'(LO), 64'(32'h12345678));
    sb.push_back({32'hCAFEBABE, 32'h12345678});
    issue(4'd3, 32'd5, 32'd0, 0);
    mt(4'd6, 32'h00000BAD, 0);
    wait_done("div0_mtlo_ignored", 9);
    sb.push_back({32'd0, 32'h80000000});
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    wait_done("div_ovf", 10);
    issue(4'd3, 32'd9, 32'd3, 1);
    chk("flush_busy", 64'(Busy), 64'(0));
    mt(4'd5, 32'h55555555, 1);
    @(negedge clk);
    chk("flush_busy2", 64'(Busy), 64'(0));
    chk("flush_hilo", {HI, LO}, {32'd0, 32'h80000000});
    issue(4'd15, 32'd3, 32'd3, 0);
    chk("unknown_busy", 64'(Busy), 64'(0));
    for (int i = 0; i < 8; i++) begin
      rop = 4'(1 + (i % 4));
      ra = $urandom;
      rb = $urandom | 32'd1;
      if (rop == 4'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd7;
      sb.push_back(model(rop, ra, rb));
      issue(rop, ra, rb, 0);
      wait_done($sformatf("rand%0d_op%0d", i, rop), rop >= 4'd3 ? 10 : 5);
    end
    mt(4'd5, 32'd0, 0);
    mt(4'd6, 32'd10, 0);
`ifdef MDU_MADD_EN
    sb.push_back({32'd0, 32'd6});
    issue(4'd7, 32'hFFFFFFFF, 32'd4, 0);
    wait_done("madd", 5);
    sb.push_back({32'd0, 32'd14});
    issue(4'd9, 32'hFFFFFFFF, 32'd8, 0);
    wait_done("msub", 5);
`else
    issue(4'd7, 32'hFFFFFFFF, 32'd4, 0);
    chk("madd_off_busy", 64'(Busy), 64'(0));
    @(negedge clk);
    chk("madd_off_hilo", {HI, LO}, {32'd0, 32'd10});
`endif
    issue(4'd1, 32'd7, 32'd7, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 64'(Busy), 64'(1));
    reset_n = 0;
    #1;
    chk("async_rst_busy", 64'(Busy), 64'(0));
    chk("async_rst_hilo", {HI, LO}, 64'(0));
    @(negedge clk);
    reset_n = 1;
    repeat (6) @(negedge clk);
    chk("post_rst_hilo", {HI, LO}, 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
